// File: rtl/pcpi_mon_pkg.sv
// pcpi_mon_pkg: shared state encoding and match constants
// for the PCPI run monitor.
package pcpi_mon_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_DONE    = 2'd1,
      ST_TIMEOUT = 2'd2
   } mon_state_e;

   localparam logic [31:0] MATCH_CALCULATE = 32'h0000_2027;
   localparam logic [31:0] MASK_CALCULATE  = 32'hFE00_707F;

   localparam logic [29:0] EXIT_ADR_DEF = 30'h0400_0001;
   localparam logic [31:0] EXIT_DAT_DEF = 32'h0000_00AD;

   function automatic logic insn_hit(
      input logic [31:0] insn,
      input logic [31:0] match,
      input logic [31:0] mask
   );
      return (insn & mask) == match;
   endfunction

endpackage

// File: rtl/pcpi_match_counter.sv
// pcpi_match_counter: one instruction-match channel with
// saturating issue counter and first-issue time stamp.
module pcpi_match_counter
   import pcpi_mon_pkg::*;
#(
   parameter int          CNT_WIDTH = 32,
   parameter logic [31:0] MATCH     = MATCH_CALCULATE,
   parameter logic [31:0] MASK      = MASK_CALCULATE
) (
   input  logic                 clk,
   input  logic                 restart,
   input  logic                 run_en,
   input  logic                 issue,
   input  logic [31:0]          insn,
   input  logic [CNT_WIDTH-1:0] cycle_now,
   output logic [CNT_WIDTH-1:0] count,
   output logic [CNT_WIDTH-1:0] stamp,
   output logic                 seen
);

   localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

   logic hit;

   assign hit = run_en & issue & insn_hit(insn, MATCH, MASK);

   // count matching issues, stamp the first one
   always_ff @(posedge clk) begin
      if (restart) begin
         count <= '0;
         stamp <= '0;
         seen  <= 1'b0;
      end else if (hit) begin
         if (count != '1)
            count <= count + ONE;
         if (!seen) begin
            stamp <= cycle_now;
            seen  <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/pcpi_run_monitor.sv
// pcpi_run_monitor: run-cycle counter, exit/timeout FSM and
// per-channel PCPI issue statistics.
module pcpi_run_monitor
   import pcpi_mon_pkg::*;
#(
   parameter int                        NUM_MATCH      = 4,
   parameter int                        CNT_WIDTH      = 32,
   parameter int unsigned               TIMEOUT_CYCLES = 2000000,
   parameter logic [29:0]               EXIT_ADR       = EXIT_ADR_DEF,
   parameter logic [31:0]               EXIT_DAT       = EXIT_DAT_DEF,
   parameter logic [32*NUM_MATCH-1:0]   MATCH_VEC      =
      {NUM_MATCH{MATCH_CALCULATE}},
   parameter logic [32*NUM_MATCH-1:0]   MASK_VEC       =
      {NUM_MATCH{MASK_CALCULATE}}
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic                           clear,
   input  logic [29:0]                    wb_adr,
   input  logic [31:0]                    wb_dat,
   input  logic                           wb_we,
   input  logic                           wb_cyc,
   input  logic                           wb_ack,
   input  logic                           pcpi_valid,
   input  logic [31:0]                    pcpi_insn,
   output logic [1:0]                     state,
   output logic                           done,
   output logic                           timeout,
   output logic [CNT_WIDTH-1:0]           cycle_count,
   output logic [NUM_MATCH*CNT_WIDTH-1:0] match_count,
   output logic [NUM_MATCH*CNT_WIDTH-1:0] first_stamp,
   output logic [NUM_MATCH-1:0]           first_valid,
   output logic [CNT_WIDTH-1:0]           calc_cycles
);

   localparam logic [CNT_WIDTH-1:0] ONE    = CNT_WIDTH'(1);
   localparam logic [63:0]          TO_LIM = 64'(TIMEOUT_CYCLES);

   mon_state_e           st;
   logic                 restart;
   logic                 run;
   logic                 prev_valid;
   logic                 issue;
   logic                 exit_hit;
   logic                 to_hit;
   logic [CNT_WIDTH-1:0] cyc_next;
   logic [CNT_WIDTH-1:0] stamp0;

   assign restart  = ~resetn | clear;
   assign run      = (st == ST_RUN);
   assign issue    = pcpi_valid & ~prev_valid;
   assign cyc_next = cycle_count + ONE;
   assign stamp0   = first_stamp[CNT_WIDTH-1:0];
   assign state    = st;

   assign exit_hit = wb_cyc & wb_we & wb_ack
                   & (wb_adr == EXIT_ADR)
                   & (wb_dat == EXIT_DAT);

   // compare at 64 bits so a limit beyond the counter range never fires
   assign to_hit = (64'(cyc_next) == TO_LIM);

   // edge detector for new PCPI issues
   always_ff @(posedge clk) begin
      if (restart)
         prev_valid <= 1'b0;
      else
         prev_valid <= pcpi_valid;
   end

   // run FSM, cycle counter and exit latency
   always_ff @(posedge clk) begin
      if (restart) begin
         st          <= ST_RUN;
         done        <= 1'b0;
         timeout     <= 1'b0;
         cycle_count <= '0;
         calc_cycles <= '0;
      end else if (run) begin
         cycle_count <= cyc_next;
         if (exit_hit) begin
            st          <= ST_DONE;
            done        <= 1'b1;
            calc_cycles <= first_valid[0] ? cyc_next - stamp0
                                          : cyc_next;
         end else if (to_hit) begin
            st      <= ST_TIMEOUT;
            timeout <= 1'b1;
         end
      end
   end

   for (genvar i = 0; i < NUM_MATCH; i++) begin : g_ch
      pcpi_match_counter #(
         .CNT_WIDTH (CNT_WIDTH),
         .MATCH     (MATCH_VEC[32*i +: 32]),
         .MASK      (MASK_VEC[32*i +: 32])
      ) u_ch (
         .clk       (clk),
         .restart   (restart),
         .run_en    (run),
         .issue     (issue),
         .insn      (pcpi_insn),
         .cycle_now (cyc_next),
         .count     (match_count[i*CNT_WIDTH +: CNT_WIDTH]),
         .stamp     (first_stamp[i*CNT_WIDTH +: CNT_WIDTH]),
         .seen      (first_valid[i])
      );
   end

endmodule

// File: doc/pcpi_run_monitor.md
# pcpi_run_monitor

Synthesizable run monitor for the picorv32 estimator platform. It watches the Wishbone data bus and the PCPI issue bus, and counts total run cycles, per-channel custom-instruction issues, and calculation latency. It also detects firmware exit and timeout. It sits beside the CPU and coprocessor in both RTL and GLS builds, replacing ad-hoc bench bookkeeping with a parametrised hardware block.

## Interface
Parameters:
- NUM_MATCH, 4: number of instruction-match channels (1..8).
- CNT_WIDTH, 32: width of all counters and time stamps.
- TIMEOUT_CYCLES, 2000000: run-cycle limit.
- EXIT_ADR, 30'h0400_0001: word address of the exit register.
- EXIT_DAT, 32'h0000_00AD: exit code.
- MATCH_VEC, {NUM_MATCH{32'h0000_2027}}: packed per-channel match values; channel i is bits [32i+31:32i].
- MASK_VEC, {NUM_MATCH{32'hFE00_707F}}: packed per-channel masks.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- resetn  in  1  reset, synchronous and active-low.
- clear  in  1  synchronous restart; same effect as reset.
- wb_adr  in  30  bus word address [31:2].
- wb_dat  in  32  bus write data.
- wb_we  in  1  write enable.
- wb_cyc  in  1  bus cycle.
- wb_ack  in  1  slave acknowledge.
- pcpi_valid  in  1  PCPI instruction valid.
- pcpi_insn  in  32  PCPI instruction word.
- state  out  2  0 = RUN, 1 = DONE, 2 = TIMEOUT.
- done  out  1  exit detected.
- timeout  out  1  timeout reached.
- cycle_count  out  CNT_WIDTH  run cycles.
- match_count  out  NUM_MATCH*CNT_WIDTH  issues per channel.
- first_stamp  out  NUM_MATCH*CNT_WIDTH  cycle_count at each channel's first issue.
- first_valid  out  NUM_MATCH  the channel has seen at least one issue.
- calc_cycles  out  CNT_WIDTH  exit cycle minus first_stamp[0].

## Operation
- After reset, the FSM is in RUN.
  - RUN -> DONE on a write handshake where wb_cyc & wb_we & wb_ack are all 1, wb_adr == EXIT_ADR and wb_dat == EXIT_DAT.
  - RUN -> TIMEOUT when the incremented cycle_count would equal TIMEOUT_CYCLES.
  - DONE and TIMEOUT are terminal. Only resetn=0 or clear=1 leaves them.
- Exit and timeout on the same edge: DONE wins.
- clear and exit on the same edge: clear wins, and the block returns to RUN with all counters at 0.
- cycle_count increments by 1 on every edge in RUN, including the edge that detects exit or timeout. It is frozen in DONE and TIMEOUT.
- Issue detection: an issue occurs on an edge where pcpi_valid=1 and the registered previous pcpi_valid was 0. A held pcpi_valid (coprocessor wait) counts once.
- Channel i counts an issue when (pcpi_insn & MASK_i) == MATCH_i. Several channels may count the same issue.
- match_count saturates at all-ones. Issues are ignored outside RUN.
- On a channel's first issue, first_stamp[i] takes the post-increment cycle_count of that edge and first_valid[i] is set.
- calc_cycles is loaded on the DONE transition:
  - first_valid[0]=1: exit cycle_count - first_stamp[0], modulo 2^CNT_WIDTH.
  - first_valid[0]=0: the exit cycle_count.
- calc_cycles holds 0 in RUN and TIMEOUT.

## Timing
- All outputs are registered. An event on edge k is visible after edge k. There is no combinational input-to-output path.
- Reset/clear values: state=RUN, done=0, timeout=0, all counts, stamps and calc_cycles = 0, first_valid=0, previous-valid register = 0.
- An issue present in the first cycle after reset release counts: the previous-valid register is 0.
- Reset asserted mid-run drops all results. Nothing is retained.

## Structure
- Package pcpi_mon_pkg holds:
  - the state encoding (RUN, DONE, TIMEOUT);
  - MATCH_CALCULATE = 32'h2027 and MASK_CALCULATE = 32'hFE00707F;
  - the default exit address and data.
- Sub-module pcpi_match_counter holds one channel: mask/compare, saturating counter, first stamp and valid flag. It takes an issue strobe, a run enable and the current cycle_count, and is instantiated NUM_MATCH times in a generate loop.
- The top level holds the FSM, the cycle counter, the previous-valid register and calc_cycles.

## Test plan
- Exit path: release reset, write EXIT_DAT to EXIT_ADR with an ack at run cycle 500 -> done=1, state=1, cycle_count=500, cycle_count frozen afterwards.
- Timeout: TIMEOUT_CYCLES=64, no exit -> timeout=1 when cycle_count=64, state=2. An exit write afterwards is ignored.
- Issue counting: insn 32'h0000_2027 held valid for 5 cycles, then 3 separate 1-cycle issues -> match_count[0]=4. Insn 32'h0000_2033 -> no count on default channels.
- Latency: first 0x2027 issue at cycle 100, exit at cycle 350 -> first_stamp[0]=100, calc_cycles=250. With no issue, exit at cycle 350 -> calc_cycles=350, first_valid[0]=0.
- Boundaries: exit and timeout on the same edge -> DONE. clear asserted together with the exit write -> RUN with counts 0. CNT_WIDTH=4 with 20 issues -> match_count=15.
- Multi-channel: MATCH_VEC channel 1 = 32'h0000_4027 with the same mask; interleave 0x2027 and 0x4027 issues -> independent counts and first stamps.
